// File: rtl/seq_controller_pkg.sv
// seq_pkg: shared definitions for the Y86-64 SEQ sequencer.
//   - icode constants (I_HALT .. I_POPQ)
//   - processor status encodings (stat_t)
//   - sequencer state enum (state_t)
//   - icode classification record (icode_class_t)
//   - REG_NONE register id meaning "no destination"
package seq_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_CMOVXX = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] REG_NONE = 4'hF;

    typedef enum logic [1:0] {
        STAT_AOK = 2'b00,
        STAT_HLT = 2'b01,
        STAT_ADR = 2'b10,
        STAT_INS = 2'b11
    } stat_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_MEMORY,
        S_WRITEBACK,
        S_PCUPD,
        S_HALT
    } state_t;

    typedef struct packed {
        logic needs_mem;
        logic mem_wr;
        logic sets_cc;
        logic is_cmov;
    } icode_class_t;

endpackage

// File: rtl/seq_icode_class.sv
// seq_icode_class: combinational icode classifier.
//   icode  in   instruction code
//   cls    out  {needs_mem, mem_wr, sets_cc, is_cmov}
module seq_icode_class
    import seq_pkg::*;
(
    input  logic [3:0]   icode,
    output icode_class_t cls
);

    always_comb begin
        cls = '0;
        case (icode)
            I_RMMOVQ, I_CALL, I_PUSHQ: begin
                cls.needs_mem = 1'b1;
                cls.mem_wr    = 1'b1;
            end
            I_MRMOVQ, I_RET, I_POPQ: cls.needs_mem = 1'b1;
            I_OPQ:                   cls.sets_cc   = 1'b1;
            I_CMOVXX:                cls.is_cmov   = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/seq_controller.sv
// seq_controller: multi-cycle sequencer for the Y86-64 SEQ datapath.
// Steps FETCH -> DECODE -> EXECUTE -> [MEMORY] -> WRITEBACK -> PCUPD, holding
// in MEMORY until mem_ack or a timeout. Owns PC, stage strobes, register-file
// write strobes and the status code.
// Ports:
//   Clk, Rst (async, active high), start
//   icode, instr_valid, imem_error, cnd, dstE, dstM, new_PC   from stages
//   mem_ack, dmem_error                                        from data memory
//   PC, fetch_en, decode_en, execute_en, cc_en                 to stages
//   mem_req, mem_wr, rf_wrE, rf_wrM, stat, busy                control/status
//   cycle_cnt, instr_cnt                                       perf counters
// Build option: define SEQ_PERF_CNT_EN to get live counters; otherwise both
// counter outputs are constant 0.
module seq_controller
    import seq_pkg::*;
#(
    parameter logic [63:0] RESET_PC    = 64'h0,
    parameter int          MEM_TIMEOUT = 16
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        start,
    input  logic [3:0]  icode,
    input  logic        instr_valid,
    input  logic        imem_error,
    input  logic        cnd,
    input  logic [3:0]  dstE,
    input  logic [3:0]  dstM,
    input  logic [63:0] new_PC,
    input  logic        mem_ack,
    input  logic        dmem_error,
    output logic [63:0] PC,
    output logic        fetch_en,
    output logic        decode_en,
    output logic        execute_en,
    output logic        cc_en,
    output logic        mem_req,
    output logic        mem_wr,
    output logic        rf_wrE,
    output logic        rf_wrM,
    output logic [1:0]  stat,
    output logic        busy,
    output logic [63:0] cycle_cnt,
    output logic [63:0] instr_cnt
);

    state_t       state, state_n;
    stat_t        stat_q, stat_n;
    logic [63:0]  pc_q;
    logic [3:0]   icode_q;
    logic [7:0]   tmo_cnt;
    logic         wr_e_q, wr_m_q;
    logic         wr_e_n, wr_m_n;
    logic         tmo_hit;
    icode_class_t cls;

    // Classify the latched icode so every icode-dependent output is a
    // function of registers only.
    seq_icode_class u_cls (
        .icode (icode_q),
        .cls   (cls)
    );

    assign tmo_hit = (int'(tmo_cnt) >= MEM_TIMEOUT - 1);

    // Writeback strobes are resolved at the cycle that enters WRITEBACK.
    // A shared destination suppresses E so the memory result wins.
    assign wr_e_n = (dstE != REG_NONE) && (!cls.is_cmov || cnd) && (dstE != dstM);
    assign wr_m_n = (dstM != REG_NONE);

    always_comb begin
        state_n = state;
        stat_n  = stat_q;
        case (state)
            S_IDLE:    if (start) state_n = S_FETCH;
            S_FETCH: begin
                if (imem_error) begin
                    stat_n  = STAT_ADR;
                    state_n = S_HALT;
                end else if (!instr_valid) begin
                    stat_n  = STAT_INS;
                    state_n = S_HALT;
                end else if (icode == I_HALT) begin
                    stat_n  = STAT_HLT;
                    state_n = S_HALT;
                end else begin
                    state_n = S_DECODE;
                end
            end
            S_DECODE:  state_n = S_EXECUTE;
            S_EXECUTE: state_n = cls.needs_mem ? S_MEMORY : S_WRITEBACK;
            S_MEMORY: begin
                // ack beats a simultaneous timeout expiry
                if (mem_ack) begin
                    if (dmem_error) begin
                        stat_n  = STAT_ADR;
                        state_n = S_HALT;
                    end else begin
                        state_n = S_WRITEBACK;
                    end
                end else if (tmo_hit) begin
                    stat_n  = STAT_ADR;
                    state_n = S_HALT;
                end
            end
            S_WRITEBACK: state_n = S_PCUPD;
            S_PCUPD:     state_n = S_FETCH;
            S_HALT:      ;
            default:     state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state   <= S_IDLE;
            stat_q  <= STAT_AOK;
            pc_q    <= RESET_PC;
            icode_q <= I_HALT;
            tmo_cnt <= '0;
            wr_e_q  <= 1'b0;
            wr_m_q  <= 1'b0;
        end else begin
            state  <= state_n;
            stat_q <= stat_n;
            if (state == S_FETCH) icode_q <= icode;
            if (state == S_PCUPD) pc_q <= new_PC;
            // counts MEMORY cycles; any other state leaves it cleared for entry
            tmo_cnt <= (state == S_MEMORY) ? tmo_cnt + 8'd1 : 8'd0;
            if (state_n == S_WRITEBACK) begin
                wr_e_q <= wr_e_n;
                wr_m_q <= wr_m_n;
            end
        end
    end

    assign PC         = pc_q;
    assign stat       = stat_q;
    assign fetch_en   = (state == S_FETCH);
    assign decode_en  = (state == S_DECODE);
    assign execute_en = (state == S_EXECUTE);
    assign cc_en      = (state == S_EXECUTE) && cls.sets_cc;
    assign mem_req    = (state == S_MEMORY);
    assign mem_wr     = (state == S_MEMORY) && cls.mem_wr;
    assign rf_wrE     = (state == S_WRITEBACK) && wr_e_q;
    assign rf_wrM     = (state == S_WRITEBACK) && wr_m_q;
    assign busy       = (state != S_IDLE) && (state != S_HALT);

`ifdef SEQ_PERF_CNT_EN
    logic [63:0] cyc_q, ins_q;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            cyc_q <= '0;
            ins_q <= '0;
        end else begin
            if (busy)             cyc_q <= cyc_q + 64'd1;
            if (state == S_PCUPD) ins_q <= ins_q + 64'd1;
        end
    end

    assign cycle_cnt = cyc_q;
    assign instr_cnt = ins_q;
`else
    assign cycle_cnt = '0;
    assign instr_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_controller.sv
// tb_seq_controller: scoreboard bench for seq_controller. The stimulus
// process computes each instruction's expected outcome from the ISA-level
// rules and queues it; the monitor gathers what the DUT did between FETCH
// strobes and compares when an instruction completes.
module tb_seq_controller;

    localparam int T = 16;
`ifdef SEQ_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        Clk, Rst, start, instr_valid, imem_error, cnd, mem_ack, dmem_error;
    logic [3:0]  icode, dstE, dstM;
    logic [63:0] new_PC, PC, cycle_cnt, instr_cnt;
    logic        fetch_en, decode_en, execute_en, cc_en, mem_req, mem_wr, rf_wrE, rf_wrM, busy;
    logic [1:0]  stat;

    seq_controller #(.RESET_PC(64'h0), .MEM_TIMEOUT(T)) dut (
        .Clk(Clk), .Rst(Rst), .start(start), .icode(icode), .instr_valid(instr_valid),
        .imem_error(imem_error), .cnd(cnd), .dstE(dstE), .dstM(dstM), .new_PC(new_PC),
        .mem_ack(mem_ack), .dmem_error(dmem_error), .PC(PC), .fetch_en(fetch_en),
        .decode_en(decode_en), .execute_en(execute_en), .cc_en(cc_en), .mem_req(mem_req),
        .mem_wr(mem_wr), .rf_wrE(rf_wrE), .rf_wrM(rf_wrM), .stat(stat), .busy(busy),
        .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
    );

    typedef struct {
        logic [63:0] pc;
        int stat, lat, mreq, mwr, wre, wrm, cc, wrpos;
        logic [63:0] ccnt, icnt;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0, errors = 0;
    logic [63:0] pc_m, cum_m, icnt_m;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
        end
    endtask

    // ---------------- monitor ----------------
    bit in_instr = 1'b0;
    int a_cyc, a_mreq, a_mwr, a_wre, a_wrm, a_cc, a_wrpos;
    bit a_ok;

    task automatic finalize();
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL sb_underflow actual=instruction_seen expected=none");
            return;
        end
        e = exp_q.pop_front();
        chk("latency",  a_cyc,   e.lat);
        chk("pc",       PC,      e.pc);
        chk("stat",     stat,    e.stat);
        chk("mem_req",  a_mreq,  e.mreq);
        chk("mem_wr",   a_mwr,   e.mwr);
        chk("rf_wrE",   a_wre,   e.wre);
        chk("rf_wrM",   a_wrm,   e.wrm);
        chk("cc_en",    a_cc,    e.cc);
        chk("wb_pos",   a_wrpos, e.wrpos);
        chk("order",    a_ok,    1);
        chk("cycle_cnt", cycle_cnt, e.ccnt);
        chk("instr_cnt", instr_cnt, e.icnt);
    endtask

    always @(negedge Clk) begin
        if (Rst) begin
            in_instr = 1'b0;
        end else begin
            if (in_instr && (fetch_en || !busy)) finalize();
            if (fetch_en) begin
                in_instr = 1'b1;
                a_cyc = 0; a_mreq = 0; a_mwr = 0; a_wre = 0; a_wrm = 0; a_cc = 0;
                a_wrpos = -1; a_ok = 1'b1;
            end else if (!busy) begin
                in_instr = 1'b0;
            end
            if (in_instr) begin
                if (a_cyc == 0 && !fetch_en)   a_ok = 1'b0;
                if (a_cyc == 1 && !decode_en)  a_ok = 1'b0;
                if (a_cyc == 2 && !execute_en) a_ok = 1'b0;
                if ($countones({fetch_en, decode_en, execute_en, mem_req, rf_wrE | rf_wrM}) > 1) a_ok = 1'b0;
                if (cc_en && !execute_en) a_ok = 1'b0;
                if (mem_wr && !mem_req)   a_ok = 1'b0;
                if (rf_wrE || rf_wrM) a_wrpos = a_cyc;
                a_mreq += int'(mem_req);
                a_mwr  += int'(mem_wr);
                a_wre  += int'(rf_wrE);
                a_wrm  += int'(rf_wrM);
                a_cc   += int'(cc_en);
                a_cyc++;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic check_reset(input string tag);
        chk({tag, "_strobes"}, {fetch_en, decode_en, execute_en, cc_en, mem_req, mem_wr, rf_wrE, rf_wrM, busy}, 0);
        chk({tag, "_pc"},   PC,   64'h0);
        chk({tag, "_stat"}, stat, 0);
        chk({tag, "_ccnt"}, cycle_cnt, 0);
        chk({tag, "_icnt"}, instr_cnt, 0);
    endtask

    // Asserts Rst (from wherever the DUT is), checks values at once, then releases.
    task automatic do_reset(input string tag);
        Rst = 1'b1;
        #1;
        check_reset(tag);
        @(posedge Clk); @(posedge Clk); #1;
        Rst = 1'b0; start = 1'b0; mem_ack = 1'b0; dmem_error = 1'b0;
        exp_q.delete();
        pc_m = 64'h0; cum_m = 64'h0; icnt_m = 64'h0;
    endtask

    // Pulse start from IDLE; returns #1 into the first FETCH cycle.
    task automatic start_run();
        start = 1'b1;
        @(posedge Clk); #1;
        start = 1'b0;
    endtask

    // Called #1 into a FETCH cycle. d = cycles until mem_ack in MEMORY.
    task automatic run_instr(input logic [3:0] ic, input bit valid, input bit imerr, input bit cnd_i,
                             input logic [3:0] de, input logic [3:0] dm, input logic [63:0] npc,
                             input int d, input bit derr, output bit halted);
        exp_t e;
        bit   mem;
        int   m;
        e = '{pc: 64'h0, stat: 0, lat: 0, mreq: 0, mwr: 0, wre: 0, wrm: 0, cc: 0,
              wrpos: -1, ccnt: 64'h0, icnt: 64'h0};
        mem = ic inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
        m = 0;
        if (imerr)          begin e.stat = 2; e.lat = 1; end
        else if (!valid)    begin e.stat = 3; e.lat = 1; end
        else if (ic == 0)   begin e.stat = 1; e.lat = 1; end
        else begin
            e.cc = (ic == 4'h6) ? 1 : 0;
            if (mem) begin
                m = (d > T) ? T : d;
                e.mreq = m;
                e.mwr  = (ic inside {4'h4, 4'h8, 4'hA}) ? m : 0;
            end
            if (mem && d > T)      begin e.stat = 2; e.lat = 3 + T; end
            else if (mem && derr)  begin e.stat = 2; e.lat = 3 + d; end
            else begin
                e.lat = 5 + (mem ? d : 0);
                e.wre = (de != 4'hF && (ic != 4'h2 || cnd_i) && de != dm) ? 1 : 0;
                e.wrm = (dm != 4'hF) ? 1 : 0;
                if (e.wre + e.wrm > 0) e.wrpos = e.lat - 2;
            end
        end
        halted = (e.stat != 0);
        if (!halted) pc_m = npc;
        e.pc = pc_m;
        cum_m += 64'(e.lat);
        if (!halted) icnt_m += 64'd1;
        e.ccnt = PERF ? cum_m : 64'h0;
        e.icnt = PERF ? icnt_m : 64'h0;
        exp_q.push_back(e);

        icode = ic; instr_valid = valid; imem_error = imerr; cnd = cnd_i;
        dstE = de; dstM = dm; new_PC = npc;
        for (int i = 0; i < e.lat; i++) begin
            if (mem && e.lat > 1 && i >= 3 && i < 3 + m) mem_ack = (i == 3 + d - 1);
            else mem_ack = 1'($urandom);       // must be ignored outside MEMORY
            dmem_error = mem_ack ? 1'(derr) : 1'($urandom);
            start = 1'($urandom);              // must be ignored while busy/halted
            @(posedge Clk); #1;
        end
        mem_ack = 1'b0; dmem_error = 1'b0; start = 1'b0;
    endtask

    task automatic rand_instr(output bit halted);
        logic [3:0]  ic, de, dm;
        logic [63:0] npc;
        int          r, d;
        ic = 4'($urandom_range(1, 11));
        de = 4'($urandom_range(0, 15));
        dm = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 3) == 0) dm = de;
        npc = {$urandom, $urandom};
        r = $urandom_range(0, 9);
        d = (r < 7) ? $urandom_range(1, 4) : (r == 7) ? T : (r == 8) ? T + 1 : 1;
        run_instr(ic, $urandom_range(0, 19) != 0, $urandom_range(0, 29) == 0, 1'($urandom),
                  de, dm, npc, d, $urandom_range(0, 14) == 0, halted);
    endtask

    initial begin
        bit h;
        Rst = 1'b1; start = 1'b0; icode = 4'h0; instr_valid = 1'b0; imem_error = 1'b0;
        cnd = 1'b0; dstE = 4'hF; dstM = 4'hF; new_PC = 64'h0; mem_ack = 1'b0; dmem_error = 1'b0;
        #2;
        do_reset("reset0");

        // directed program: irmovq, mrmovq(ack after 3), popq, cmovle(cnd=0), halt @0x20
        start_run();
        run_instr(4'h3, 1, 0, 0, 4'h2, 4'hF, 64'd10, 1, 0, h);
        chk("irmovq_pc", PC, 64'd10);
        run_instr(4'h5, 1, 0, 0, 4'hF, 4'h3, 64'h14, 3, 0, h);
        run_instr(4'hB, 1, 0, 0, 4'h4, 4'h4, 64'h18, 1, 0, h);
        run_instr(4'h2, 1, 0, 0, 4'h1, 4'hF, 64'h20, 1, 0, h);
        run_instr(4'h0, 1, 0, 0, 4'hF, 4'hF, 64'h99, 1, 0, h);
        for (int k = 0; k < 3; k++) begin
            start = 1'b1; @(posedge Clk); #1; start = 1'b0; @(posedge Clk); #1;
        end
        chk("halt_busy", busy, 0);
        chk("halt_pc",   PC,   64'h20);
        chk("halt_stat", stat, 1);

        // rmmovq with no ack -> timeout ADR
        do_reset("reset1");
        start_run();
        run_instr(4'h4, 1, 0, 0, 4'hF, 4'hF, 64'h8, 99, 0, h);
        // illegal instruction -> INS
        do_reset("reset2");
        start_run();
        run_instr(4'h6, 0, 0, 0, 4'h1, 4'hF, 64'h8, 1, 0, h);
        // dmem_error with ack -> ADR
        do_reset("reset3");
        start_run();
        run_instr(4'h5, 1, 0, 0, 4'hF, 4'h2, 64'h8, 2, 1, h);
        // three nops then halt: counters 5/10/15 after each nop
        do_reset("reset4");
        start_run();
        for (int k = 1; k <= 3; k++) run_instr(4'h1, 1, 0, 0, 4'hF, 4'hF, 64'(k), 1, 0, h);
        run_instr(4'h0, 1, 0, 0, 4'hF, 4'hF, 64'h0, 1, 0, h);

        // reset asserted in the middle of a MEMORY cycle
        do_reset("reset5");
        start_run();
        icode = 4'h5; instr_valid = 1'b1; imem_error = 1'b0; dstE = 4'hF; dstM = 4'h3;
        repeat (3) begin @(posedge Clk); #1; end
        chk("mid_mem_req", mem_req, 1);
        #2;
        do_reset("rst_in_mem");

        // randomized programs
        for (int p = 0; p < 8; p++) begin
            do_reset("reset_rand");
            start_run();
            h = 1'b0;
            for (int n = 0; n < 15 && !h; n++) rand_instr(h);
            if (!h) run_instr(4'h0, 1, 0, 0, 4'hF, 4'hF, 64'h0, 1, 0, h);
        end

        repeat (3) @(posedge Clk);
        #1;
        chk("sb_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_controller.md
# seq_controller

Multi-cycle sequencer for the Y86-64 SEQ datapath (fetch, decode, execute, memory, writeback, PC update). It replaces the free-running testbench clock toggling with a state machine that advances one stage at a time and holds in the memory stage until the data memory acknowledges. It owns the architectural PC, the stage enables, the register-file write strobes and the processor status code. It sits between the top-level harness and the stage modules.

## Interface
- RESET_PC, 64'h0: PC value loaded on reset.
- MEM_TIMEOUT, 16: maximum MEMORY-state cycles without mem_ack before an ADR fault.
- Clk  in  1  system clock; all state changes on rising edge.
- Rst  in  1  asynchronous, active-high reset.
- start  in  1  pulse; begins execution from the current PC when idle.
- icode  in  4  instruction code from fetch.
- instr_valid  in  1  fetch decoded a legal instruction.
- imem_error  in  1  instruction fetch address fault.
- cnd  in  1  condition result from execute (gates cmovXX writeback).
- dstE, dstM  in  4 each  destination registers from decode; 4'hF = none.
- new_PC  in  64  next PC from the PC-update logic.
- mem_ack  in  1  data memory completed the access.
- dmem_error  in  1  data memory address fault; valid with mem_ack.
- PC  out  64  architectural PC driven to fetch.
- fetch_en, decode_en, execute_en  out  1 each  one-hot stage strobes.
- cc_en  out  1  load condition codes (OPq in EXECUTE only).
- mem_req, mem_wr  out  1 each  data-memory request and direction.
- rf_wrE, rf_wrM  out  1 each  register-file write strobes.
- stat  out  2  00 AOK, 01 HLT, 10 ADR, 11 INS.
- busy  out  1  high in every state except IDLE and HALT.
- cycle_cnt, instr_cnt  out  64 each  performance counters (see Configuration).

## Operation
- States: IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PCUPD, HALT.
- IDLE: start=1 -> FETCH. Otherwise hold.
- FETCH: fetch_en=1. imem_error -> stat=ADR, HALT. Else !instr_valid -> INS, HALT. Else icode=0 -> HLT, HALT. Else -> DECODE.
- DECODE: decode_en=1 -> EXECUTE.
- EXECUTE: execute_en=1; cc_en=1 iff icode=6. -> MEMORY if icode is in {4,5,8,9,A,B}, else WRITEBACK.
- MEMORY: mem_req=1; mem_wr=1 for icode 4, 8, A. On mem_ack: dmem_error -> ADR, HALT; else -> WRITEBACK. If MEM_TIMEOUT cycles elapse without mem_ack -> ADR, HALT.
- WRITEBACK: rf_wrE=1 iff dstE!=F and (icode!=2 or cnd). rf_wrM=1 iff dstM!=F. If dstE==dstM, rf_wrE is forced to 0, so the M result wins (popq %rsp). -> PCUPD.
- PCUPD: PC<=new_PC. Increment instr_cnt. -> FETCH.
- HALT: sticky; start is ignored. Only Rst exits. PC holds the faulting or halting instruction address.

## Timing
- Reset values: state IDLE, PC=RESET_PC, stat=AOK, all strobes 0, busy 0, counters 0.
- All outputs are registered or decoded from the state register only; no input-to-output combinational path.
- Latency: non-memory instruction = 5 cycles (FETCH to PCUPD). Memory instruction = 6 + (cycles until mem_ack - 1).
- mem_ack in the first MEMORY cycle means 1 MEMORY cycle. mem_ack is ignored outside MEMORY.
- Timeout counter: 8-bit, cleared on MEMORY entry. A fault is raised when the count reaches MEM_TIMEOUT with no ack. If ack arrives in the same cycle as expiry, the ack wins.
- start while busy: ignored. Rst mid-instruction: immediate asynchronous return to reset values. Partial register writes are impossible because strobes exist only in WRITEBACK.

## Configuration
- SEQ_PERF_CNT_EN defined:
  - cycle_cnt increments every cycle while busy.
  - instr_cnt increments in PCUPD.
  - Both wrap modulo 2^64.
- Not defined: both outputs are tied to 0 and no counter flops are generated.

## Structure
- Package seq_pkg holds:
  - icode constants (HALT=0 … POPQ=B)
  - stat encodings AOK/HLT/ADR/INS
  - state enum
  - REG_NONE=4'hF
- One sub-module, seq_icode_class: combinational map icode -> needs_mem, mem_wr, sets_cc, is_cmov. Instantiated once.

## Test plan
- Reset, then start with an irmovq at PC 0 and new_PC=10: strobes step one per cycle, rf_wrE only in WRITEBACK, PC=10 after 5 cycles, stat=AOK.
- mrmovq with mem_ack delayed 3 cycles: mem_req high for 3 cycles, mem_wr=0, rf_wrM=1 once, total latency 8 cycles.
- popq with dstE=dstM=4: rf_wrM=1 and rf_wrE=0. cmovle with cnd=0: rf_wrE=0.
- icode=0 fetched at PC 0x20: stat=HLT, busy=0, PC stays 0x20, later start pulses are ignored.
- rmmovq with no mem_ack and MEM_TIMEOUT=16: ADR after 16 MEMORY cycles. Repeat with !instr_valid: INS. Repeat with dmem_error on ack: ADR.
- Rst asserted in MEMORY: all outputs return to reset values immediately. With SEQ_PERF_CNT_EN, 3 nops give instr_cnt=3 and cycle_cnt=15.
